// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from EX, aligns load data,
// and emits the register-write bundle for WB and the ID bypass network.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  output logic        mem_allowin,
  input  logic        ex_to_mem_valid,
  input  logic [31:0] ex_pc,
  input  logic [37:0] ex_rf_zip,
  input  logic        ex_res_from_mem,
  input  logic [2:0]  ex_ld_op,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [37:0] mem_rf_zip,
  output logic [37:0] mem_fwd_zip
);

  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  logic        mem_valid_q;
  logic        mem_valid_d;
  logic [31:0] pc_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] alu_result_q;
  logic        res_from_mem_q;
  logic [2:0]  ld_op_q;
  logic        first_cycle_q;
  logic        first_cycle_d;
  logic [31:0] rdata_buf_q;

  logic        ready_go;
  logic        accept;
  logic [31:0] rdata_sel;
  logic [1:0]  addr_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_b;
  logic        is_bu;
  logic        is_h;
  logic        is_hu;
  logic [31:0] load_res;
  logic [31:0] final_wdata;

  assign ready_go        = 1'b1;
  assign mem_allowin     = ~mem_valid_q | (ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid_q & ready_go;
  assign accept          = ex_to_mem_valid & mem_allowin;

  // Next valid: refill from EX whenever the slot opens, else hold.
  always_comb begin
    mem_valid_d = mem_valid_q;
    if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
    end
  end

  // first_cycle marks the single cycle in which the SRAM data is live.
  always_comb begin
    first_cycle_d = accept;
  end

  // Valid and first-cycle flags; reset empties the stage immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q   <= 1'b0;
      first_cycle_q <= 1'b0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      first_cycle_q <= first_cycle_d;
    end
  end

  // Payload loads only on accept, so a stalled instruction stays stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q           <= 32'd0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      alu_result_q   <= 32'd0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= 3'd0;
    end else if (accept) begin
      pc_q           <= ex_pc;
      rf_we_q        <= ex_rf_zip[37];
      rf_waddr_q     <= ex_rf_zip[36:32];
      alu_result_q   <= ex_rf_zip[31:0];
      res_from_mem_q <= ex_res_from_mem;
      ld_op_q        <= ex_ld_op;
    end
  end

  // Keep the SRAM word so a load stalled by WB still sees its data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf_q <= 32'd0;
    end else if (first_cycle_q) begin
      rdata_buf_q <= data_sram_rdata;
    end
  end

  assign rdata_sel = first_cycle_q ? data_sram_rdata : rdata_buf_q;
  assign addr_lo   = alu_result_q[1:0];

  // Byte lane chosen by the low address bits.
  always_comb begin
    byte_sel = rdata_sel[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = rdata_sel[7:0];
      2'd1: byte_sel = rdata_sel[15:8];
      2'd2: byte_sel = rdata_sel[23:16];
      2'd3: byte_sel = rdata_sel[31:24];
      default: byte_sel = rdata_sel[7:0];
    endcase
  end

  assign half_sel = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  assign is_b  = (ld_op_q == LD_B);
  assign is_bu = (ld_op_q == LD_BU);
  assign is_h  = (ld_op_q == LD_H);
  assign is_hu = (ld_op_q == LD_HU);

  // Extend the selected lane; unknown encodings behave as a word load.
  always_comb begin
    load_res = rdata_sel;
    unique case (1'b1)
      is_b:    load_res = {{24{byte_sel[7]}}, byte_sel};
      is_bu:   load_res = {24'd0, byte_sel};
      is_h:    load_res = {{16{half_sel[15]}}, half_sel};
      is_hu:   load_res = {16'd0, half_sel};
      default: load_res = rdata_sel;
    endcase
  end

  assign final_wdata = res_from_mem_q ? load_res : alu_result_q;

  assign mem_pc      = pc_q;
  assign mem_rf_zip  = {rf_we_q, rf_waddr_q, final_wdata};
  assign mem_fwd_zip = {rf_we_q & mem_valid_q, rf_waddr_q, final_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed traffic
// against a lane-arithmetic load model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        mem_allowin;
  logic        ex_to_mem_valid;
  logic [31:0] ex_pc;
  logic [37:0] ex_rf_zip;
  logic        ex_res_from_mem;
  logic [2:0]  ex_ld_op;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf_zip;
  logic [37:0] mem_fwd_zip;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_allowin     (mem_allowin),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_pc           (ex_pc),
    .ex_rf_zip       (ex_rf_zip),
    .ex_res_from_mem (ex_res_from_mem),
    .ex_ld_op        (ex_ld_op),
    .data_sram_rdata (data_sram_rdata),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_pc          (mem_pc),
    .mem_rf_zip      (mem_rf_zip),
    .mem_fwd_zip     (mem_fwd_zip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [37:0] zip;
    logic [31:0] rd;
  } item_t;

  item_t q[$];
  item_t pend_item;
  bit    pend;
  bit    mon_en;
  int    checks;
  int    errors;

  task automatic chk(input string name, input logic [37:0] got,
                     input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Load result from the byte/half lane arithmetic of the ISA.
  function automatic logic [31:0] ld_model(input logic [2:0] op,
                                           input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] h;
    s = rd >> (8 * int'(addr[1:0]));
    h = rd >> (16 * int'(addr[1]));
    case (op)
      3'd1: return {{24{s[7]}}, s[7:0]};
      3'd3: return {24'd0, s[7:0]};
      3'd2: return {{16{h[15]}}, h[15:0]};
      3'd4: return {16'd0, h[15:0]};
      default: return rd;
    endcase
  endfunction

  // One cycle of stimulus; the model decides acceptance itself.
  task automatic step(input bit v, input logic [31:0] pc,
                      input bit we, input logic [4:0] wa,
                      input logic [31:0] alu, input bit ld,
                      input logic [2:0] op, input logic [31:0] rd,
                      input bit wb, input logic [31:0] junk);
    @(posedge clk);
    #1;
    if (pend) begin
      q.push_back(pend_item);
      data_sram_rdata = pend_item.rd;
      pend = 0;
    end else begin
      data_sram_rdata = junk;
    end
    ex_to_mem_valid = v;
    ex_pc           = pc;
    ex_rf_zip       = {we, wa, alu};
    ex_res_from_mem = ld;
    ex_ld_op        = op;
    wb_allowin      = wb;
    if (v && (q.size() == 0 || wb)) begin
      pend = 1;
      pend_item.pc  = pc;
      pend_item.rd  = rd;
      pend_item.zip = {we, wa, ld ? ld_model(op, alu, rd) : alu};
    end
  endtask

  task automatic idle(input bit wb, input logic [31:0] junk);
    step(0, 32'd0, 0, 5'd0, 32'd0, 0, 3'd0, 32'd0, wb, junk);
  endtask

  // Monitor: compares the stage against the scoreboard head each cycle.
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      chk("allowin", 38'(mem_allowin),
          38'((q.size() == 0) || wb_allowin));
      chk("valid", 38'(mem_to_wb_valid), 38'(q.size() != 0));
      if (q.size() != 0) begin
        chk("pc", 38'(mem_pc), 38'(q[0].pc));
        chk("rf_zip", mem_rf_zip, q[0].zip);
        chk("fwd_zip", mem_fwd_zip, q[0].zip);
        if (wb_allowin) void'(q.pop_front());
      end else begin
        chk("fwd_we_idle", 38'(mem_fwd_zip[37]), 38'(0));
      end
    end
  end

  logic [31:0] pcs [3];

  initial begin
    checks = 0;
    errors = 0;
    pend   = 0;
    mon_en = 0;
    resetn = 1'b0;
    ex_to_mem_valid = 1'b0;
    ex_pc = '0;
    ex_rf_zip = '0;
    ex_res_from_mem = 1'b0;
    ex_ld_op = '0;
    data_sram_rdata = '0;
    wb_allowin = 1'b0;

    // Reset held with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      ex_to_mem_valid = 1'($urandom);
      ex_pc           = $urandom;
      ex_rf_zip       = {6'($urandom), 32'($urandom)};
      ex_res_from_mem = 1'($urandom);
      ex_ld_op        = 3'($urandom);
      data_sram_rdata = $urandom;
      wb_allowin      = 1'($urandom);
      @(negedge clk);
      chk("rst_valid", 38'(mem_to_wb_valid), 38'(0));
      chk("rst_allowin", 38'(mem_allowin), 38'(1));
      chk("rst_fwd", mem_fwd_zip, 38'(0));
      chk("rst_zip", mem_rf_zip, 38'(0));
      chk("rst_pc", 38'(mem_pc), 38'(0));
    end
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b0;
    wb_allowin = 1'b1;
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 38'(mem_to_wb_valid), 38'(0));
      chk("post_rst_fwd", mem_fwd_zip, 38'(0));
      chk("post_rst_pc", 38'(mem_pc), 38'(0));
    end
    mon_en = 1;

    // ld.b / ld.bu / ld.h / ld.hu directed vectors.
    step(1, 32'h100, 1, 5'd3, 32'h1003, 1, 3'd1, 32'h80FF1234, 1, 0);
    idle(1, 32'h0);
    @(negedge clk);
    chk("ld_b", 38'(mem_rf_zip[31:0]), 38'(32'hFFFFFF80));
    step(1, 32'h104, 1, 5'd3, 32'h1003, 1, 3'd3, 32'h80FF1234, 1, 0);
    idle(1, 32'h0);
    @(negedge clk);
    chk("ld_bu", 38'(mem_rf_zip[31:0]), 38'(32'h00000080));
    step(1, 32'h108, 1, 5'd4, 32'h2002, 1, 3'd2, 32'hBEEF0001, 1, 0);
    idle(1, 32'h0);
    @(negedge clk);
    chk("ld_h", 38'(mem_rf_zip[31:0]), 38'(32'hFFFFBEEF));
    step(1, 32'h10C, 1, 5'd4, 32'h2002, 1, 3'd4, 32'hBEEF0001, 1, 0);
    idle(1, 32'h0);
    @(negedge clk);
    chk("ld_hu", 38'(mem_rf_zip[31:0]), 38'(32'h0000BEEF));
    step(1, 32'h110, 1, 5'd4, 32'h2000, 1, 3'd2, 32'hBEEF0001, 1, 0);
    idle(1, 32'h0);
    @(negedge clk);
    chk("ld_h_lo", 38'(mem_rf_zip[31:0]), 38'(32'h00000001));

    // Stall: load held three cycles while SRAM data changes.
    step(1, 32'h200, 1, 5'd7, 32'h3000, 1, 3'd0, 32'h12345678, 1, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 32'hDEADBEEF);
      @(negedge clk);
      chk("stall_data", 38'(mem_rf_zip[31:0]), 38'(32'h12345678));
      chk("stall_allowin", 38'(mem_allowin), 38'(0));
    end
    idle(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("stall_release", 38'(mem_to_wb_valid & wb_allowin), 38'(1));
    idle(1, 32'h0);
    @(negedge clk);
    chk("stall_gone", 38'(mem_to_wb_valid), 38'(0));

    // Back-to-back non-loads, no bubbles.
    pcs[0] = 32'h300;
    pcs[1] = 32'h304;
    pcs[2] = 32'h308;
    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        step(1, pcs[i], 1, 5'(i + 1), 32'($urandom), 0, 3'd0, 32'd0, 1, 0);
      else
        idle(1, 32'h0);
      if (i > 0) begin
        @(negedge clk);
        chk("b2b_pc", 38'(mem_pc), 38'(pcs[i - 1]));
        chk("b2b_fwd_we", 38'(mem_fwd_zip[37]), 38'(1));
      end
    end
    idle(1, 32'h0);
    @(negedge clk);
    chk("b2b_drain_we", 38'(mem_fwd_zip[37]), 38'(0));

    // Async reset while a load is stalled.
    step(1, 32'h400, 1, 5'd9, 32'h4001, 1, 3'd1, 32'hCAFEF00D, 1, 0);
    idle(0, 32'h0);
    idle(0, 32'h0);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_valid", 38'(mem_to_wb_valid), 38'(0));
    chk("async_fwd", mem_fwd_zip, 38'(0));
    chk("async_allowin", 38'(mem_allowin), 38'(1));
    q.delete();
    pend = 0;
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, 1'($urandom),
           5'($urandom), $urandom, 1'($urandom), 3'($urandom),
           $urandom, ($urandom_range(0, 9) < 7), $urandom);
    end
    for (int i = 0; i < 4; i++) idle(1, $urandom);
    @(negedge clk);
    chk("final_empty", 38'(q.size()), 38'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order pipeline, between the EX stage and the write-back stage.
- Accepts one instruction per cycle from EX and holds it under a valid/allowin handshake.
- Completes loads by selecting, aligning and extending data returned by the data SRAM.
- Produces the packed register-write bundle for WB and a forwarding bundle for the ID-stage bypass network.

Parameters:
- none (datapath widths fixed: 32-bit data and PC, 5-bit register address).

Ports:
- clk  input  1  pipeline clock.
- resetn  input  1  asynchronous active-low reset.
- mem_allowin  output  1  MEM can accept an instruction from EX this cycle.
- ex_to_mem_valid  input  1  EX presents a valid instruction.
- ex_pc  input  32  PC of the EX instruction.
- ex_rf_zip  input  38  {rf_we, rf_waddr[4:0], alu_result[31:0]}; alu_result is the load address for loads.
- ex_res_from_mem  input  1  instruction is a load.
- ex_ld_op  input  3  load type: 0 = ld.w, 1 = ld.b, 2 = ld.h, 3 = ld.bu, 4 = ld.hu; 5-7 are treated as ld.w.
- data_sram_rdata  input  32  SRAM read data; valid only in the first cycle an instruction is in MEM.
- wb_allowin  input  1  WB can accept.
- mem_to_wb_valid  output  1  MEM presents a valid instruction to WB.
- mem_pc  output  32  PC of the MEM instruction.
- mem_rf_zip  output  38  {rf_we, rf_waddr, final_wdata} to WB.
- mem_fwd_zip  output  38  {rf_we & mem_valid, rf_waddr, final_wdata} to ID bypass.

Behaviour:
- State registers: mem_valid, pc, rf_we, rf_waddr, alu_result, res_from_mem, ld_op, first_cycle, rdata_buf.
  - All are cleared to 0 asynchronously while resetn = 0.
  - Resulting reset outputs: mem_allowin = 1, mem_to_wb_valid = 0, every zip = 0, mem_pc = 0.
- Handshake:
  - ready_go = 1.
  - mem_allowin = ~mem_valid | (ready_go & wb_allowin).
  - mem_to_wb_valid = mem_valid & ready_go.
- Valid update: on each posedge, if mem_allowin then mem_valid <= ex_to_mem_valid; otherwise mem_valid holds.
- Payload capture:
  - Payload registers load only when ex_to_mem_valid & mem_allowin.
  - Otherwise they hold, so a stalled instruction stays stable.
- first_cycle:
  - Set to 1 on the edge that accepts a valid instruction.
  - Cleared to 0 on every other edge.
- rdata_buf captures data_sram_rdata on every edge where first_cycle = 1.
- Read-data select: rdata_sel = first_cycle ? data_sram_rdata : rdata_buf. A load stalled by WB for N cycles therefore keeps its correct data.
- Load alignment, with a = alu_result[1:0]:
  - shifted = rdata_sel >> (8*a).
  - ld.b: sign-extend shifted[7:0].
  - ld.bu: zero-extend shifted[7:0].
  - ld.h: sign-extend half selected by a[1] (a[0] ignored).
  - ld.hu: zero-extend half selected by a[1] (a[0] ignored).
  - ld.w: rdata_sel unchanged (a ignored).
  - Misaligned-address exceptions are not detected here.
- final_wdata = res_from_mem ? load_result : alu_result.
- Latency: one cycle EX→MEM. final_wdata is combinational from registered state plus SRAM data.
- Simultaneous accept and leave (mem_valid = 1, wb_allowin = 1, ex_to_mem_valid = 1): the new instruction replaces the old on the same edge; no bubble.
- Drain: if ex_to_mem_valid = 0 while mem_allowin = 1, mem_valid drops to 0. The payload may hold stale values, but every visible write-enable is qualified by valid downstream.
- Reset mid-operation: an in-flight instruction is discarded immediately; the stage is empty on resetn deassertion.

Test Plan:
- Reset: hold resetn = 0 with random inputs → mem_to_wb_valid = 0, mem_allowin = 1, mem_fwd_zip = 0; outputs stay at these values until the first accepting edge after release.
- ld.b sign extension: ex_ld_op = 1, alu_result = 0x1003, rdata = 0x80FF_1234 → final_wdata = 0xFFFF_FF80.
  - Same access with ld.bu → 0x0000_0080.
- ld.h / ld.hu: alu_result = 0x2002, rdata = 0xBEEF_0001.
  - ld.h → 0xFFFF_BEEF.
  - ld.hu → 0x0000_BEEF.
  - alu_result = 0x2000 with ld.h → 0x0000_0001.
- Stall hold: load accepted with rdata = 0x1234_5678, then wb_allowin = 0 for 3 cycles while rdata changes to 0xDEAD_BEEF.
  - final_wdata stays 0x1234_5678 throughout; mem_allowin = 0.
  - Instruction passes to WB on the cycle wb_allowin returns to 1.
- Back-to-back flow: three non-load instructions on consecutive cycles with wb_allowin = 1 → each mem_pc appears one cycle after its ex_pc, with no bubbles. Forward zip we = 1 only while mem_valid = 1.
- Async reset mid-stall: assert resetn = 0 between clock edges while a stalled load is held → mem_valid and mem_fwd_zip go to 0 without waiting for a clock edge.
